// File: rtl/game_board_chars_draw_pkg.sv
// game_pkg: constants, types and the glyph generator shared by the
// board-character overlay stage and its font ROM.
//
// Contents:
//   CELL_PX, MAX_CELLS, VALUE_W   - board geometry constants
//   cell_value_t                  - one board cell value (0 = empty)
//   vga_fields_t                  - flattened copy of the vga_bus fields,
//                                   used for the pipeline delay registers
//   GLYPH_COLOR_DEF/CURSOR_COLOR_DEF - default colours
//   font_row()                    - glyph bitmap row, bit 15 = leftmost pixel
package game_pkg;

    localparam int CELL_PX   = 16;
    localparam int MAX_CELLS = 16;
    localparam int VALUE_W   = 5;

    typedef logic [VALUE_W-1:0] cell_value_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_fields_t;

    localparam logic [11:0] GLYPH_COLOR_DEF  = 12'hF_F_F;
    localparam logic [11:0] CURSOR_COLOR_DEF = 12'h0_4_8;

    // Glyph g (1..16) lights pixel (px,py) inside the 14x14 interior when
    // (px ^ py) < g, so every glyph is distinct and glyph 16 is a filled
    // square. Glyph 0 and 17..31 are blank.
    function automatic logic [15:0] font_row(input logic [4:0] glyph,
                                             input logic [3:0] py);
        logic [15:0] r;
        r = '0;
        for (int px = 1; px <= 14; px++) begin
            if ((glyph >= 5'd1) && (glyph <= 5'd16) &&
                (py >= 4'd1) && (py <= 4'd14) &&
                ({1'b0, 4'(px) ^ py} < glyph))
                r[15-px] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/game_board_chars_draw_if.sv
// vga_bus: pixel stream between overlay stages.
//   hcount/vcount : pixel coordinates
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 4:4:4 colour
// master drives the stream, slave receives it.
interface vga_bus;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/game_board_chars_draw_font_rom.sv
// board_font_rom: 512 x 16 glyph ROM (32 glyphs x 16 rows) with a
// registered read; the contents come from game_pkg::font_row.
//   clk     : pixel clock
//   rst     : synchronous active-high reset, clears the read register
//   addr_i  : {glyph[4:0], py[3:0]}
//   data_o  : glyph row, bit 15 = leftmost pixel, valid one cycle after addr_i
module board_font_rom
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  addr_i,
    output logic [15:0] data_o
);

    logic [15:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= font_row(addr_i[8:4], addr_i[3:0]);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/game_board_chars_draw.sv
// game_board_chars_draw: draws board cell values as 16x16 glyphs inside the
// centred board area and passes the vga_bus timing through with a fixed
// 3-cycle delay.
//   clk, rst            : pixel clock, synchronous active-high reset
//   is_game_on          : drawing enable, latched at frame start
//   board_size          : box size n (board is n^2 x n^2), latched at frame start
//   board               : cell values [row][col], sampled every pixel
//   cursor_row/col      : highlighted cell (GAME_CURSOR_HIGHLIGHT_EN only)
//   bus_in / bus_out    : upstream / downstream pixel stream
// Optional feature macro: GAME_CURSOR_HIGHLIGHT_EN (cursor cell highlight).
// Pipeline: S1 cell decode + board select, S2 font ROM read, S3 colour mux.
module game_board_chars_draw
    import game_pkg::*;
#(
    parameter int          SCREEN_WIDTH  = 1024,
    parameter int          SCREEN_HEIGHT = 768,
    parameter logic [11:0] GLYPH_COLOR   = GLYPH_COLOR_DEF,
    parameter logic [11:0] CURSOR_COLOR  = CURSOR_COLOR_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          is_game_on,
    input  logic [2:0]                    board_size,
    input  cell_value_t [15:0][15:0]      board,
`ifdef GAME_CURSOR_HIGHLIGHT_EN
    input  logic [3:0]                    cursor_row,
    input  logic [3:0]                    cursor_col,
`endif
    vga_bus.slave                         bus_in,
    vga_bus.master                        bus_out
);

    // frame-latched settings
    logic       on_q;
    logic [2:0] size_q;
    logic [3:0] cur_row_q, cur_col_q;

    // S1 outputs
    logic        area1_q, hit1_q;
    logic [4:0]  glyph1_q;
    logic [3:0]  px1_q, py1_q;
    vga_fields_t bus1_q;

    // S2 outputs
    logic        area2_q, hit2_q;
    logic [3:0]  px2_q;
    vga_fields_t bus2_q;
    logic [15:0] rom_data;

    // S1 combinational decode
    logic [15:0] n_cells, span, x0, y0, hc16, vc16, dx, dy;
    logic        draw_en, area_d, hit_d;
    logic [3:0]  row_d, col_d;
    cell_value_t cell_v;
    logic [4:0]  glyph_d;
    vga_fields_t bus_in_f;
    logic        frame_start;

    // S3 combinational mux
    logic        glyph_bit, draw3;
    logic [11:0] rgb_d;

    logic unused_ok;
    assign unused_ok = ^{dx[15:8], dy[15:8]};

    assign bus_in_f = '{hcount: bus_in.hcount, vcount: bus_in.vcount,
                        hsync: bus_in.hsync, vsync: bus_in.vsync,
                        hblnk: bus_in.hblnk, vblnk: bus_in.vblnk,
                        rgb: bus_in.rgb};

    assign frame_start = (bus_in.hcount == 11'd0) && (bus_in.vcount == 11'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            on_q      <= 1'b0;
            size_q    <= '0;
            cur_row_q <= '0;
            cur_col_q <= '0;
        end else if (frame_start) begin
            on_q   <= is_game_on;
            size_q <= board_size;
`ifdef GAME_CURSOR_HIGHLIGHT_EN
            cur_row_q <= cursor_row;
            cur_col_q <= cursor_col;
`endif
        end
    end

    always_comb begin
        n_cells = 16'(size_q) * 16'(size_q);
        span    = n_cells << 4;
        x0      = (16'(SCREEN_WIDTH)  - span) >> 1;
        y0      = (16'(SCREEN_HEIGHT) - span) >> 1;
        hc16    = 16'(bus_in.hcount);
        vc16    = 16'(bus_in.vcount);
        dx      = hc16 - x0;
        dy      = vc16 - y0;
        draw_en = on_q && (size_q >= 3'd2) && (size_q <= 3'd4);
        area_d  = draw_en && (hc16 >= x0) && (hc16 < x0 + span) &&
                  (vc16 >= y0) && (vc16 < y0 + span);
        col_d   = dx[7:4];
        row_d   = dy[7:4];
        cell_v  = board[row_d][col_d];
        // out-of-range values share the blank glyph 0
        glyph_d = ((cell_v >= 5'd1) && (cell_v <= 5'd16)) ? cell_v : 5'd0;
        hit_d   = 1'b0;
`ifdef GAME_CURSOR_HIGHLIGHT_EN
        hit_d   = area_d && (row_d == cur_row_q) && (col_d == cur_col_q) &&
                  (16'(cur_row_q) < n_cells) && (16'(cur_col_q) < n_cells);
`else
        hit_d   = hit_d & (cur_row_q == cur_col_q);
`endif
    end

    // S1
    always_ff @(posedge clk) begin
        if (rst) begin
            area1_q  <= 1'b0;
            hit1_q   <= 1'b0;
            glyph1_q <= '0;
            px1_q    <= '0;
            py1_q    <= '0;
            bus1_q   <= '0;
        end else begin
            area1_q  <= area_d;
            hit1_q   <= hit_d;
            glyph1_q <= glyph_d;
            px1_q    <= dx[3:0];
            py1_q    <= dy[3:0];
            bus1_q   <= bus_in_f;
        end
    end

    // S2: ROM read with the remaining per-pixel state carried alongside
    board_font_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr_i ({glyph1_q, py1_q}),
        .data_o (rom_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            area2_q <= 1'b0;
            hit2_q  <= 1'b0;
            px2_q   <= '0;
            bus2_q  <= '0;
        end else begin
            area2_q <= area1_q;
            hit2_q  <= hit1_q;
            px2_q   <= px1_q;
            bus2_q  <= bus1_q;
        end
    end

    // S3
    always_comb begin
        glyph_bit = rom_data[4'd15 - px2_q];
        draw3     = area2_q && !bus2_q.hblnk && !bus2_q.vblnk;
        rgb_d     = bus2_q.rgb;
        if (draw3 && glyph_bit) begin
            rgb_d = GLYPH_COLOR;
        end else if (draw3 && hit2_q) begin
            rgb_d = CURSOR_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out.hcount <= '0;
            bus_out.vcount <= '0;
            bus_out.hsync  <= 1'b0;
            bus_out.vsync  <= 1'b0;
            bus_out.hblnk  <= 1'b0;
            bus_out.vblnk  <= 1'b0;
            bus_out.rgb    <= '0;
        end else begin
            bus_out.hcount <= bus2_q.hcount;
            bus_out.vcount <= bus2_q.vcount;
            bus_out.hsync  <= bus2_q.hsync;
            bus_out.vsync  <= bus2_q.vsync;
            bus_out.hblnk  <= bus2_q.hblnk;
            bus_out.vblnk  <= bus2_q.vblnk;
            bus_out.rgb    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_game_board_chars_draw.sv
// Bench for game_board_chars_draw: directed table, hand sequences for
// frame latching / reset, and a randomized stream against a pixel-level model.
module tb_game_board_chars_draw;
    import game_pkg::*;

    localparam int W = 1024;
    localparam int H = 768;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     is_game_on;
    logic [2:0]               board_size;
    cell_value_t [15:0][15:0] board;
    logic [3:0]               cursor_row, cursor_col;

    vga_bus bin ();
    vga_bus bout ();

    always #5 clk = ~clk;

    game_board_chars_draw dut (
        .clk        (clk),
        .rst        (rst),
        .is_game_on (is_game_on),
        .board_size (board_size),
        .board      (board),
`ifdef GAME_CURSOR_HIGHLIGHT_EN
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
`endif
        .bus_in     (bin),
        .bus_out    (bout)
    );

    typedef struct {
        vga_fields_t f;
        int          tag;
    } exp_t;

    typedef struct {
        logic        on;
        logic [2:0]  size;
        int          hc;
        int          vc;
        logic        hb;
        logic [11:0] rgb_in;
        logic [11:0] exp_rgb;
    } vec_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_on, m_size, m_crow, m_ccol;

    // pixel-level reference: which pixels of glyph v are lit
    function automatic bit glyph_px(int v, int px, int py);
        return (v >= 1) && (v <= 16) && (px >= 1) && (px <= 14) &&
               (py >= 1) && (py <= 14) && ((px ^ py) < v);
    endfunction

    function automatic logic [11:0] model_rgb(int hc, int vc, logic hb,
                                              logic vb, logic [11:0] rgb);
        int n, x0, y0, col, row;
        if (m_on == 0 || m_size < 2 || m_size > 4 || hb || vb) return rgb;
        n  = m_size * m_size;
        x0 = (W - 16 * n) / 2;
        y0 = (H - 16 * n) / 2;
        if (hc < x0 || hc >= x0 + 16 * n || vc < y0 || vc >= y0 + 16 * n)
            return rgb;
        col = (hc - x0) / 16;
        row = (vc - y0) / 16;
        if (glyph_px(int'(board[row][col]), (hc - x0) % 16, (vc - y0) % 16))
            return GLYPH_COLOR_DEF;
`ifdef GAME_CURSOR_HIGHLIGHT_EN
        if (row == m_crow && col == m_ccol) return CURSOR_COLOR_DEF;
`endif
        return rgb;
    endfunction

    task automatic check_out(input exp_t e);
        vga_fields_t act;
        act = {bout.hcount, bout.vcount, bout.hsync, bout.vsync,
               bout.hblnk, bout.vblnk, bout.rgb};
        tests++;
        if (act !== e.f) begin
            fails++;
            $display("FAIL pix tag=%0d got h=%0d v=%0d s=%b%b b=%b%b rgb=%h want h=%0d v=%0d s=%b%b b=%b%b rgb=%h",
                     e.tag, act.hcount, act.vcount, act.hsync, act.vsync,
                     act.hblnk, act.vblnk, act.rgb, e.f.hcount, e.f.vcount,
                     e.f.hsync, e.f.vsync, e.f.hblnk, e.f.vblnk, e.f.rgb);
        end
    endtask

    // Present one pixel, queue its expected output, advance one clock and
    // check whatever pixel is due at the output.
    task automatic drive(input int hc, input int vc, input logic hb,
                         input logic vb, input logic [11:0] rgb,
                         input logic use_exp, input logic [11:0] xrgb,
                         input int tag);
        exp_t e;
        logic hs, vs;
        hs = 1'($urandom);
        vs = 1'($urandom);
        bin.hcount = 11'(hc);
        bin.vcount = 11'(vc);
        bin.hsync  = hs;
        bin.vsync  = vs;
        bin.hblnk  = hb;
        bin.vblnk  = vb;
        bin.rgb    = rgb;
        e.f   = '{hcount: 11'(hc), vcount: 11'(vc), hsync: hs, vsync: vs,
                  hblnk: hb, vblnk: vb,
                  rgb: use_exp ? xrgb : model_rgb(hc, vc, hb, vb, rgb)};
        e.tag = tag;
        q.push_back(e);
        if (hc == 0 && vc == 0) begin
            m_on   = int'(is_game_on);
            m_size = int'(board_size);
            m_crow = int'(cursor_row);
            m_ccol = int'(cursor_col);
        end
        @(posedge clk);
        #1;
        if (q.size() >= 3) check_out(q.pop_front());
    endtask

    task automatic latch(input logic on, input logic [2:0] size);
        is_game_on = on;
        board_size = size;
        drive(0, 0, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000, -2);
    endtask

    task automatic do_reset();
        exp_t z;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            z.f = '0;
            z.tag = -1;
            check_out(z);
        end
        q.delete();
        m_on = 0; m_size = 0; m_crow = 0; m_ccol = 0;
        rst = 1'b0;
        // two zero outputs still in flight after release
        q.push_back(z);
        q.push_back(z);
    endtask

    vec_t vec[16];

    initial begin
        rst        = 1'b1;
        is_game_on = 1'b0;
        board_size = 3'd0;
        cursor_row = 4'd7;
        cursor_col = 4'd7;
        board      = '0;
        board[0][0]   = 5'd1;
        board[15][15] = 5'd16;
        board[1][1]   = 5'd20;
        bin.hcount = '0; bin.vcount = '0; bin.hsync = 1'b0; bin.vsync = 1'b0;
        bin.hblnk = 1'b0; bin.vblnk = 1'b0; bin.rgb = '0;

        // size3: X0=440 Y0=312; size4: X0=384 Y0=256; size2: X0=480 Y0=352
        vec[0]  = '{1'b1, 3'd3, 441, 313, 1'b0, 12'h123, 12'hFFF};
        vec[1]  = '{1'b1, 3'd3, 440, 312, 1'b0, 12'h123, 12'h123};
        vec[2]  = '{1'b1, 3'd3, 442, 313, 1'b0, 12'h124, 12'h124};
        vec[3]  = '{1'b1, 3'd3, 455, 327, 1'b0, 12'h125, 12'h125};
        vec[4]  = '{1'b1, 3'd3, 457, 329, 1'b0, 12'h0AB, 12'h0AB};
        vec[5]  = '{1'b0, 3'd3, 441, 313, 1'b0, 12'h321, 12'h321};
        vec[6]  = '{1'b1, 3'd5, 385, 257, 1'b0, 12'h555, 12'h555};
        vec[7]  = '{1'b1, 3'd1, 441, 313, 1'b0, 12'h111, 12'h111};
        vec[8]  = '{1'b1, 3'd4, 625, 497, 1'b0, 12'h200, 12'hFFF};
        vec[9]  = '{1'b1, 3'd4, 638, 510, 1'b0, 12'h201, 12'hFFF};
        vec[10] = '{1'b1, 3'd4, 640, 497, 1'b0, 12'h202, 12'h202};
        vec[11] = '{1'b1, 3'd4, 639, 511, 1'b0, 12'h203, 12'h203};
        vec[12] = '{1'b1, 3'd4, 385, 257, 1'b0, 12'h204, 12'hFFF};
        vec[13] = '{1'b1, 3'd3, 441, 313, 1'b1, 12'h0C0, 12'h0C0};
        vec[14] = '{1'b1, 3'd2, 481, 353, 1'b0, 12'h0D0, 12'hFFF};
        vec[15] = '{1'b1, 3'd4, 383, 257, 1'b0, 12'h0E0, 12'h0E0};

        do_reset();

        // pass-through with drawing disabled
        for (int i = 0; i < 20; i++)
            drive(430 + i, 312, 1'b0, 1'b0, 12'(i * 37), 1'b1, 12'(i * 37), 100 + i);

        for (int i = 0; i < 16; i++) begin
            latch(vec[i].on, vec[i].size);
            drive(vec[i].hc, vec[i].vc, vec[i].hb, 1'b0, vec[i].rgb_in,
                  1'b1, vec[i].exp_rgb, i);
        end

        // board_size changes mid-frame: geometry holds until the next latch
        latch(1'b1, 3'd3);
        board_size = 3'd4;
        drive(0, 300, 1'b0, 1'b0, 12'h777, 1'b1, 12'h777, 200);
        drive(441, 313, 1'b0, 1'b0, 12'h778, 1'b1, 12'hFFF, 201);
        drive(385, 257, 1'b0, 1'b0, 12'h779, 1'b1, 12'h779, 202);
        latch(1'b1, 3'd4);
        drive(385, 257, 1'b0, 1'b0, 12'h77A, 1'b1, 12'hFFF, 203);

        // reset mid-frame: blank until the next frame latch
        do_reset();
        is_game_on = 1'b1;
        board_size = 3'd4;
        drive(385, 257, 1'b0, 1'b0, 12'h3A3, 1'b1, 12'h3A3, 300);
        drive(625, 497, 1'b0, 1'b0, 12'h3A4, 1'b1, 12'h3A4, 301);
        latch(1'b1, 3'd4);
        drive(625, 497, 1'b0, 1'b0, 12'h3A5, 1'b1, 12'hFFF, 302);

`ifdef GAME_CURSOR_HIGHLIGHT_EN
        // cursor cell (2,5) at N=9 spans x 520..535, y 344..359
        board[2][5] = 5'd3;
        cursor_row = 4'd2;
        cursor_col = 4'd5;
        latch(1'b1, 3'd3);
        drive(521, 345, 1'b0, 1'b0, 12'h100, 1'b1, 12'hFFF, 400);
        drive(522, 345, 1'b0, 1'b0, 12'h101, 1'b1, 12'h048, 401);
        drive(535, 359, 1'b0, 1'b0, 12'h102, 1'b1, 12'h048, 402);
        drive(536, 345, 1'b0, 1'b0, 12'h103, 1'b1, 12'h103, 403);
        drive(520, 360, 1'b0, 1'b0, 12'h104, 1'b1, 12'h104, 404);
`endif

        // randomized stream against the model
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                board[r][c] = ($urandom_range(0, 3) == 0) ?
                              5'($urandom_range(0, 31)) : 5'($urandom_range(0, 16));
        for (int i = 0; i < 3000; i++) begin
            int hc, vc;
            logic hb, vb;
            if (i % 250 == 0) begin
                cursor_row = 4'($urandom);
                cursor_col = 4'($urandom);
                latch(($urandom_range(0, 4) != 0),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                                                    3'($urandom_range(2, 4)));
            end
            if (i % 97 == 0) board_size = 3'($urandom);
            if (i % 13 == 0)
                board[$urandom_range(0, 15)][$urandom_range(0, 15)] =
                    5'($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0) begin
                hc = $urandom_range(1, W - 1);
                vc = $urandom_range(1, H - 1);
            end else begin
                hc = $urandom_range(370, 654);
                vc = $urandom_range(240, 528);
            end
            hb = ($urandom_range(0, 15) == 0);
            vb = ($urandom_range(0, 15) == 0);
            drive(hc, vc, hb, vb, 12'($urandom), 1'b0, 12'h000, 1000 + i);
        end

        // drain the pipeline
        repeat (3) drive(1, 1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 9000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
